// File: rtl/shift_rot_unit.sv
// -----------------------------------------------------------------------------
// shift_rot_unit
//
// Purpose:
//   Multi-cycle shift/rotate register. A WIDTH-bit word is parallel-loaded
//   while idle. A start handshake then rotates or shifts it by a programmable
//   amount, one bit position per clock. This is a serial, low-cost stand-in
//   for a barrel shifter. Completion is reported by a busy level and a
//   one-cycle done pulse.
//
// Parameters:
//   WIDTH  register width in bits (>= 2), default 8
//   AMT_W  width of the shift-amount input, default 3
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous, active-high reset
//   load_en   in   parallel load request (idle only, has priority over start)
//   load_val  in   [WIDTH]  parallel load data
//   start     in   begin an operation (idle only, when load_en=0)
//   mode      in   [2]  00 rotl, 01 rotr, 10 shl, 11 shr (sampled with start)
//   amt       in   [AMT_W] number of single-bit steps (sampled with start)
//   sin       in   serial fill bit for shifts, sampled on every step
//   op        out  [WIDTH] register contents
//   busy      out  high while an operation is in progress
//   done      out  one-cycle completion pulse
//   sout      out  bit expelled or wrapped by the most recent step
//
// Configuration macro:
//   SHIFT_ARITH_EN  when defined, mode 11 is an arithmetic right shift
//                   (the sign bit is replicated and sin is ignored). When
//                   undefined, mode 11 is a logical right shift filled from sin.
// -----------------------------------------------------------------------------
module shift_rot_unit #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [AMT_W-1:0] amt,
    input  logic             sin,
    output logic [WIDTH-1:0] op,
    output logic             busy,
    output logic             done,
    output logic             sout
);

    // The operation walks IDLE -> SHIFT (amt cycles) -> SETTLE -> DONE -> IDLE.
    // SETTLE is one wrap-up cycle between the last step and the done pulse.
    // It places done at (start edge + amt + 1) and keeps busy asserted for
    // amt+2 cycles in total. amt=0 skips SHIFT and goes straight to SETTLE.
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [1:0] MODE_ROL = 2'b00;
    localparam logic [1:0] MODE_ROR = 2'b01;
    localparam logic [1:0] MODE_SHL = 2'b10;
    localparam logic [1:0] MODE_SHR = 2'b11;

    localparam logic [AMT_W-1:0] COUNT_ONE = AMT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       r_mode;
    logic [AMT_W-1:0] r_count;
    logic [WIDTH-1:0] r_op;
    logic             r_sout;

    // One-step candidates for each mode. These are pure rewiring of r_op.
    logic [WIDTH-1:0] w_rol;
    logic [WIDTH-1:0] w_ror;
    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_shr;
    logic             w_fill;
    logic [WIDTH-1:0] w_step_op;
    logic             w_step_sout;
    logic             w_last_step;

`ifdef SHIFT_ARITH_EN
    // Arithmetic right shift: replicate the sign bit.
    assign w_fill = r_op[WIDTH-1];
`else
    // Logical right shift: fill from the serial input.
    assign w_fill = sin;
`endif

    // Per-bit neighbour selection. Bit 0 and bit WIDTH-1 are the only
    // positions whose source differs between rotates and shifts.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == 0) begin : g_lsb_left
                assign w_rol[gi] = r_op[WIDTH-1];
                assign w_shl[gi] = sin;
            end else begin : g_mid_left
                assign w_rol[gi] = r_op[gi-1];
                assign w_shl[gi] = r_op[gi-1];
            end

            if (gi == WIDTH-1) begin : g_msb_right
                assign w_ror[gi] = r_op[0];
                assign w_shr[gi] = w_fill;
            end else begin : g_mid_right
                assign w_ror[gi] = r_op[gi+1];
                assign w_shr[gi] = r_op[gi+1];
            end
        end
    endgenerate

    // Select the step result with the latched mode. Left moves expel the MSB,
    // and right moves expel the LSB.
    always_comb begin
        w_step_op   = r_op;
        w_step_sout = r_sout;
        case (r_mode)
            MODE_ROL: begin
                w_step_op   = w_rol;
                w_step_sout = r_op[WIDTH-1];
            end
            MODE_ROR: begin
                w_step_op   = w_ror;
                w_step_sout = r_op[0];
            end
            MODE_SHL: begin
                w_step_op   = w_shl;
                w_step_sout = r_op[WIDTH-1];
            end
            MODE_SHR: begin
                w_step_op   = w_shr;
                w_step_sout = r_op[0];
            end
            default: begin
                w_step_op   = r_op;
                w_step_sout = r_sout;
            end
        endcase
    end

    assign w_last_step = (r_count == COUNT_ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mode  <= MODE_ROL;
            r_count <= '0;
            r_op    <= '0;
            r_sout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load_en) begin
                        r_op <= load_val;
                    end else if (start) begin
                        r_mode  <= mode;
                        r_count <= amt;
                        r_state <= (amt != '0) ? S_SHIFT : S_SETTLE;
                    end
                end
                S_SHIFT: begin
                    r_op    <= w_step_op;
                    r_sout  <= w_step_sout;
                    r_count <= r_count - COUNT_ONE;
                    if (w_last_step) begin
                        r_state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign op   = r_op;
    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    assign sout = r_sout;

endmodule

// File: tb/tb_shift_rot_unit.sv
// -----------------------------------------------------------------------------
// tb_shift_rot_unit
//
// Self-checking bench for shift_rot_unit (WIDTH=8, AMT_W=4). A timeline model
// runs alongside the DUT. It records the edge at which each start is accepted,
// applies the steps with plain shift arithmetic at edges k+1..k+amt, and
// derives busy/done from the edge distance. A negedge process compares every
// output against the model on every cycle. Directed cases pin the model with
// literal values, and a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_shift_rot_unit;

    localparam int W  = 8;
    localparam int AW = 4;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          load_en  = 1'b0;
    logic [W-1:0]  load_val = '0;
    logic          start    = 1'b0;
    logic [1:0]    mode     = 2'b00;
    logic [AW-1:0] amt      = '0;
    logic          sin      = 1'b0;
    logic [W-1:0]  op;
    logic          busy;
    logic          done;
    logic          sout;

    int checks = 0;
    int errors = 0;
    bit cmp_en   = 1'b0;
    bit rand_sin = 1'b0;

    logic [W-1:0] hist [0:127];

    shift_rot_unit #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_val(load_val),
        .start(start), .mode(mode), .amt(amt), .sin(sin),
        .op(op), .busy(busy), .done(done), .sout(sout)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_op;
    logic         m_sout;
    logic         m_busy;
    logic         m_done;
    logic         m_active;
    logic [1:0]   m_mode;
    int           m_k;
    int           m_amt;
    int           cyc;

    // Returns {sout, new_op} for one step.
    function automatic logic [W:0] step(input logic [W-1:0] v, input logic [1:0] md, input logic s);
        logic [W-1:0] f;
        f = '0;
        case (md)
            2'b00: return {v[W-1], (v << 1) | (v >> (W-1))};
            2'b01: return {v[0], (v >> 1) | (v << (W-1))};
            2'b10: return {v[W-1], (v << 1) | W'(s)};
            default: begin
`ifdef SHIFT_ARITH_EN
                f = W'($signed(v) >>> 1);
`else
                f = (v >> 1) | (W'(s) << (W-1));
`endif
                return {v[0], f};
            end
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_op <= '0; m_sout <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0;
            m_active <= 1'b0; m_mode <= 2'b00; m_k <= 0; m_amt <= 0; cyc <= 0;
        end else begin
            cyc <= cyc + 1;
            if (!m_active) begin
                m_done <= 1'b0;
                if (load_en) begin
                    m_op <= load_val;
                end else if (start) begin
                    m_active <= 1'b1;
                    m_busy   <= 1'b1;
                    m_k      <= cyc;
                    m_mode   <= mode;
                    m_amt    <= int'(amt);
                end
            end else begin
                if (cyc - m_k <= m_amt) {m_sout, m_op} <= step(m_op, m_mode, sin);
                m_done <= (cyc - m_k == m_amt + 1);
                if (cyc - m_k == m_amt + 2) begin
                    m_active <= 1'b0;
                    m_busy   <= 1'b0;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc op",   32'(op),   32'(m_op));
            chk("cyc busy", 32'(busy), 32'(m_busy));
            chk("cyc done", 32'(done), 32'(m_done));
            chk("cyc sout", 32'(sout), 32'(m_sout));
        end
    end

    always @(negedge clk) begin
        if (rand_sin) sin = 1'($urandom_range(0, 1));
    end

    // ---------------- stimulus helpers ----------------
    task automatic load(input logic [W-1:0] v);
        @(negedge clk);
        load_en  = 1'b1;
        load_val = v;
        @(negedge clk);
        load_en  = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] m, input int a, input bit junk,
                          output int done_at, output int busy_len);
        int n;
        @(negedge clk);
        start = 1'b1; mode = m; amt = AW'(a);
        @(negedge clk);
        start = 1'b0; mode = 2'($urandom); amt = AW'($urandom);
        n = 0; done_at = -1; busy_len = 0;
        while (busy && n < 100) begin
            busy_len++;
            hist[n] = op;
            if (done && done_at < 0) done_at = n;
            if (junk && n < a) begin
                start = 1'b1; load_en = 1'b1; load_val = W'(8'h55);
            end else begin
                start = 1'b0; load_en = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0; load_en = 1'b0;
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL busy timeout: busy still %b after %0d cycles, required low", busy, n);
        end
        $display("op mode=%0d amt=%0d junk=%0d -> op=%h sout=%b done_at=%0d busy_len=%0d",
                 m, a, junk, op, sout, done_at, busy_len);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int da, bl;
        logic [W-1:0] v;
        logic [1:0]   m;
        int           a;
        bit           junk;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset op",   32'(op),   32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset done", 32'(done), 32'h0);
        chk("reset sout", 32'(sout), 32'h0);
        rst = 1'b0;
        cmp_en = 1'b1;

        // 1: rotate left by one
        load(8'h81); sin = 1'b0;
        run_op(2'b00, 1, 1'b0, da, bl);
        chk("t1 op", 32'(op), 32'h03);
        chk("t1 sout", 32'(sout), 32'h1);
        chk("t1 done_at", 32'(da), 32'd2);
        chk("t1 busy_len", 32'(bl), 32'd3);

        // 2: rotate right by three
        load(8'h01);
        run_op(2'b01, 3, 1'b0, da, bl);
        chk("t2 step1", 32'(hist[1]), 32'h80);
        chk("t2 step2", 32'(hist[2]), 32'h40);
        chk("t2 step3", 32'(hist[3]), 32'h20);
        chk("t2 done_at", 32'(da), 32'd4);
        chk("t2 sout", 32'(sout), 32'h0);

        // 3: shift left with sin=1
        load(8'hF0); sin = 1'b1;
        run_op(2'b10, 2, 1'b0, da, bl);
        chk("t3 op", 32'(op), 32'hC3);
        chk("t3 sout", 32'(sout), 32'h1);

        // 4: shift right with sin=0
        load(8'h80); sin = 1'b0;
        run_op(2'b11, 3, 1'b0, da, bl);
`ifdef SHIFT_ARITH_EN
        chk("t4 op", 32'(op), 32'hF0);
`else
        chk("t4 op", 32'(op), 32'h10);
`endif
        chk("t4 sout", 32'(sout), 32'h0);

        // 5: amt=0, then start/load pulsed while busy
        load(8'h5A);
        run_op(2'b00, 0, 1'b0, da, bl);
        chk("t5 op", 32'(op), 32'h5A);
        chk("t5 done_at", 32'(da), 32'd1);
        chk("t5 busy_len", 32'(bl), 32'd2);
        load(8'h12);
        run_op(2'b00, 5, 1'b1, da, bl);
        chk("t5 ignore op", 32'(op), 32'h42);
        chk("t5 ignore busy_len", 32'(bl), 32'd7);

        // 6: asynchronous reset mid-shift
        load(8'hA5);
        @(negedge clk); start = 1'b1; mode = 2'b00; amt = AW'(6);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6 op", 32'(op), 32'h0);
        chk("t6 busy", 32'(busy), 32'h0);
        chk("t6 done", 32'(done), 32'h0);
        chk("t6 sout", 32'(sout), 32'h0);
        $display("op async reset mid-shift -> op=%h busy=%b done=%b sout=%b", op, busy, done, sout);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t6 no done", 32'(done), 32'h0);
        end
        load(8'h81);
        run_op(2'b00, 1, 1'b0, da, bl);
        chk("t6 after op", 32'(op), 32'h03);

        // randomized phase
        rand_sin = 1'b1;
        for (int t = 0; t < 60; t++) begin
            v    = W'($urandom);
            m    = 2'($urandom);
            a    = $urandom_range(0, 15);
            junk = 1'($urandom_range(0, 1));
            load(v);
            run_op(m, a, junk, da, bl);
            chk("rand done_at", 32'(da), 32'(a + 1));
            chk("rand busy_len", 32'(bl), 32'(a + 2));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
